// File: rtl/map_table_ckpt.sv
// Speculative rename map table with a ring of branch checkpoints; reads are combinational off the registered table.
// Updates and recovery take one cycle; a checkpoint request is refused while the ring is full or a recovery is requested.
module map_table_ckpt #(
  parameter int N         = 3,
  parameter int CDB_W     = 3,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int NUM_CKPT  = 4,
  parameter int AW        = $clog2(ARCH_REGS),
  parameter int PW        = $clog2(PHYS_REGS),
  parameter int CW        = $clog2(NUM_CKPT),
  parameter int SW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N-1:0]      wr_valid,
  input  logic [N*AW-1:0]   wr_arch,
  input  logic [N*PW-1:0]   wr_ptag,
  input  logic [N*AW-1:0]   rs1_arch,
  input  logic [N*AW-1:0]   rs2_arch,
  input  logic [N*AW-1:0]   told_arch,
  output logic [N*PW-1:0]   rs1_ptag,
  output logic [N*PW-1:0]   rs2_ptag,
  output logic [N*PW-1:0]   told_ptag,
  output logic [N-1:0]      rs1_ready,
  output logic [N-1:0]      rs2_ready,
  output logic [N-1:0]      told_ready,
  input  logic [CDB_W-1:0]  cdb_valid,
  input  logic [CDB_W*PW-1:0] cdb_ptag,
  input  logic              ckpt_req,
  input  logic [SW-1:0]     ckpt_slot,
  output logic              ckpt_ack,
  output logic [CW-1:0]     ckpt_id,
  input  logic              ckpt_free,
  input  logic              recover_en,
  input  logic [CW-1:0]     recover_id,
  output logic [CW:0]       ckpt_count,
  output logic              ckpt_full
);

  logic [PW-1:0]        map_ptag_q [ARCH_REGS];
  logic [PW-1:0]        map_ptag_d [ARCH_REGS];
  logic [ARCH_REGS-1:0] map_rdy_q, map_rdy_d;
  logic [PW-1:0]        snap_ptag  [ARCH_REGS];
  logic [ARCH_REGS-1:0] snap_rdy;
  logic [PW-1:0]        ck_ptag_q  [NUM_CKPT][ARCH_REGS];
  logic [ARCH_REGS-1:0] ck_rdy_q   [NUM_CKPT];
  logic [CW-1:0]        head_q, head_d, tail_q, tail_d, rec_off;
  logic [CW:0]          count_q, count_d;
  logic                 rec_live;

  function automatic logic cdb_hit(input logic [PW-1:0] tag, input logic [CDB_W-1:0] vld,
                                   input logic [CDB_W*PW-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < CDB_W; j++)
      if (vld[j] && tags[j*PW +: PW] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Arch 0 is hardwired to {tag 0, ready}.
  for (genvar g = 0; g < N; g++) begin : g_rd
    logic [AW-1:0] a1, a2, a3;
    assign a1 = rs1_arch[g*AW +: AW];
    assign a2 = rs2_arch[g*AW +: AW];
    assign a3 = told_arch[g*AW +: AW];
    assign rs1_ptag[g*PW +: PW]  = (a1 == '0) ? '0 : map_ptag_q[a1];
    assign rs2_ptag[g*PW +: PW]  = (a2 == '0) ? '0 : map_ptag_q[a2];
    assign told_ptag[g*PW +: PW] = (a3 == '0) ? '0 : map_ptag_q[a3];
    assign rs1_ready[g]  = (a1 == '0) | map_rdy_q[a1];
    assign rs2_ready[g]  = (a2 == '0) | map_rdy_q[a2];
    assign told_ready[g] = (a3 == '0) | map_rdy_q[a3];
  end

  assign ckpt_full  = (count_q == (CW+1)'(NUM_CKPT));
  assign ckpt_ack   = ckpt_req && !ckpt_full && !recover_en;
  assign ckpt_id    = tail_q;
  assign ckpt_count = count_q;
  assign rec_off    = recover_id - head_q;
  assign rec_live   = recover_en && ({1'b0, rec_off} < count_q);

  always_comb begin
    for (int a = 0; a < ARCH_REGS; a++) begin
      map_ptag_d[a] = map_ptag_q[a];
      map_rdy_d[a]  = map_rdy_q[a] | cdb_hit(map_ptag_q[a], cdb_valid, cdb_ptag);
      snap_ptag[a]  = map_ptag_d[a];
      snap_rdy[a]   = map_rdy_d[a];
    end
    // Ascending slot order lets the youngest write to a register win; the snapshot stops at ckpt_slot.
    for (int i = 0; i < N; i++) begin
      if (wr_valid[i] && wr_arch[i*AW +: AW] != '0) begin
        map_ptag_d[wr_arch[i*AW +: AW]] = wr_ptag[i*PW +: PW];
        map_rdy_d[wr_arch[i*AW +: AW]]  = cdb_hit(wr_ptag[i*PW +: PW], cdb_valid, cdb_ptag);
        if (SW'(i) <= ckpt_slot) begin
          snap_ptag[wr_arch[i*AW +: AW]] = wr_ptag[i*PW +: PW];
          snap_rdy[wr_arch[i*AW +: AW]]  = cdb_hit(wr_ptag[i*PW +: PW], cdb_valid, cdb_ptag);
        end
      end
    end
    if (rec_live) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        map_ptag_d[a] = ck_ptag_q[recover_id][a];
        map_rdy_d[a]  = ck_rdy_q[recover_id][a] |
                        cdb_hit(ck_ptag_q[recover_id][a], cdb_valid, cdb_ptag);
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rec_live) begin
      // Everything younger than the restored checkpoint is dropped; the restored one stays live.
      tail_d  = recover_id + CW'(1);
      count_d = {1'b0, rec_off} + (CW+1)'(1);
      if (ckpt_free) begin
        head_d  = head_q + CW'(1);
        count_d = count_d - (CW+1)'(1);
      end
    end else begin
      if (ckpt_ack) begin
        tail_d  = tail_q + CW'(1);
        count_d = count_d + (CW+1)'(1);
      end
      if (ckpt_free && count_q != '0) begin
        head_d  = head_q + CW'(1);
        count_d = count_d - (CW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < ARCH_REGS; a++) map_ptag_q[a] <= PW'(a);
      map_rdy_q <= '1;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      for (int a = 0; a < ARCH_REGS; a++) map_ptag_q[a] <= map_ptag_d[a];
      map_rdy_q <= map_rdy_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Checkpoint payload needs no reset: liveness is tracked solely by head/count.
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CKPT; c++)
      for (int a = 0; a < ARCH_REGS; a++)
        ck_rdy_q[c][a] <= ck_rdy_q[c][a] | cdb_hit(ck_ptag_q[c][a], cdb_valid, cdb_ptag);
    if (ckpt_ack) begin
      for (int a = 0; a < ARCH_REGS; a++) ck_ptag_q[tail_q][a] <= snap_ptag[a];
      ck_rdy_q[tail_q] <= snap_rdy;
    end
  end

endmodule

// File: tb/tb_map_table_ckpt.sv
// Directed bench for map_table_ckpt: per-cycle vector table plus a hand sequence for partial-slot checkpoints.
module tb_map_table_ckpt;

  logic        clock, reset_n;
  logic [2:0]  wr_valid;
  logic [14:0] wr_arch;
  logic [17:0] wr_ptag;
  logic [14:0] rs1_arch, rs2_arch, told_arch;
  logic [17:0] rs1_ptag, rs2_ptag, told_ptag;
  logic [2:0]  rs1_ready, rs2_ready, told_ready;
  logic [2:0]  cdb_valid;
  logic [17:0] cdb_ptag;
  logic        ckpt_req;
  logic [1:0]  ckpt_slot;
  logic        ckpt_ack;
  logic [1:0]  ckpt_id;
  logic        ckpt_free;
  logic        recover_en;
  logic [1:0]  recover_id;
  logic [2:0]  ckpt_count;
  logic        ckpt_full;

  map_table_ckpt dut (
    .clock(clock), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_arch(wr_arch), .wr_ptag(wr_ptag),
    .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .told_arch(told_arch),
    .rs1_ptag(rs1_ptag), .rs2_ptag(rs2_ptag), .told_ptag(told_ptag),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .told_ready(told_ready),
    .cdb_valid(cdb_valid), .cdb_ptag(cdb_ptag),
    .ckpt_req(ckpt_req), .ckpt_slot(ckpt_slot), .ckpt_ack(ckpt_ack), .ckpt_id(ckpt_id),
    .ckpt_free(ckpt_free), .recover_en(recover_en), .recover_id(recover_id),
    .ckpt_count(ckpt_count), .ckpt_full(ckpt_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic [2:0] wv;
    logic [4:0] wa0, wa1, wa2;
    logic [5:0] wp0, wp1, wp2;
    logic [2:0] cv;
    logic [5:0] cp0, cp1, cp2;
    logic       req;
    logic [1:0] cslot;
    logic       fr, rec;
    logic [1:0] rid;
    logic [4:0] r1a, r2a, toa;
    logic [5:0] e1p, e2p, etp;
    logic       e1r, e2r, etr, eack;
    logic [1:0] eid;
    logic [2:0] ecnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int cnt);
    vec_t r;
    r = '0;
    r.e1r = 1'b1; r.e2r = 1'b1; r.etr = 1'b1;
    r.ecnt = 3'(cnt);
    return r;
  endfunction

  task automatic idle_inputs();
    wr_valid = '0; wr_arch = '0; wr_ptag = '0;
    rs1_arch = '0; rs2_arch = '0; told_arch = '0;
    cdb_valid = '0; cdb_ptag = '0;
    ckpt_req = 1'b0; ckpt_slot = '0; ckpt_free = 1'b0;
    recover_en = 1'b0; recover_id = '0;
  endtask

  task automatic apply(input vec_t x);
    wr_valid  = x.wv;
    wr_arch   = {x.wa2, x.wa1, x.wa0};
    wr_ptag   = {x.wp2, x.wp1, x.wp0};
    cdb_valid = x.cv;
    cdb_ptag  = {x.cp2, x.cp1, x.cp0};
    ckpt_req  = x.req; ckpt_slot = x.cslot; ckpt_free = x.fr;
    recover_en = x.rec; recover_id = x.rid;
    rs1_arch  = {10'd0, x.r1a};
    rs2_arch  = {10'd0, x.r2a};
    told_arch = {10'd0, x.toa};
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    // Test 1 + 2: reset contents, ordered writes, arch-0 write ignored, CDB without bypass
    v = mk(0); v.r1a = 5; v.e1p = 5; v.toa = 31; v.etp = 31; tbl.push_back(v);
    v = mk(0); v.wv = 3'b111; v.wa0 = 3; v.wp0 = 40; v.wa1 = 0; v.wp1 = 9; v.wa2 = 3; v.wp2 = 41;
    v.cv = 3'b001; v.cp0 = 40; v.r1a = 3; v.e1p = 3; tbl.push_back(v);
    v = mk(0); v.cv = 3'b100; v.cp2 = 41; v.r1a = 3; v.e1p = 41; v.e1r = 0; tbl.push_back(v);
    // Test 3: checkpoint of slot 0 only, then restore
    v = mk(0); v.wv = 3'b011; v.wa0 = 4; v.wp0 = 50; v.wa1 = 6; v.wp1 = 51; v.req = 1;
    v.eack = 1; v.eid = 0; v.r1a = 3; v.e1p = 41; tbl.push_back(v);
    v = mk(1); v.rec = 1; v.rid = 0; v.req = 1; v.r1a = 4; v.e1p = 50; v.e1r = 0;
    v.r2a = 6; v.e2p = 51; v.e2r = 0; tbl.push_back(v);
    // Test 4: stored checkpoint picks up a later CDB
    v = mk(1); v.r1a = 4; v.e1p = 50; v.e1r = 0; v.r2a = 6; v.e2p = 6; v.toa = 3; v.etp = 41;
    v.wv = 3'b001; v.wa0 = 7; v.wp0 = 52; v.req = 1; v.eack = 1; v.eid = 1; tbl.push_back(v);
    v = mk(2); v.wv = 3'b001; v.wa0 = 7; v.wp0 = 53; v.r1a = 7; v.e1p = 52; v.e1r = 0; tbl.push_back(v);
    v = mk(2); v.cv = 3'b010; v.cp1 = 52; v.r1a = 7; v.e1p = 53; v.e1r = 0; tbl.push_back(v);
    v = mk(2); v.rec = 1; v.rid = 1; v.r1a = 7; v.e1p = 53; v.e1r = 0; tbl.push_back(v);
    v = mk(2); v.fr = 1; v.r1a = 7; v.e1p = 52; v.r2a = 4; v.e2p = 50; v.e2r = 0; tbl.push_back(v);
    v = mk(1); v.fr = 1; tbl.push_back(v);
    // Empty ring: free ignored, non-live recover ignored so the write lands
    v = mk(0); v.fr = 1; v.rec = 1; v.rid = 2; v.req = 1; v.wv = 3'b001; v.wa0 = 9; v.wp0 = 60; tbl.push_back(v);
    v = mk(0); v.r1a = 9; v.e1p = 60; v.e1r = 0; v.req = 1; v.eack = 1; v.eid = 2; tbl.push_back(v);
    v = mk(0); v.rst = 1; v.r1a = 9; v.e1p = 9; v.r2a = 7; v.e2p = 7; v.toa = 4; v.etp = 4; tbl.push_back(v);
    // Test 5: fill, reject when full, wrap
    v = mk(0); v.req = 1; v.eack = 1; v.eid = 0; tbl.push_back(v);
    v = mk(1); v.req = 1; v.eack = 1; v.eid = 1; tbl.push_back(v);
    v = mk(2); v.req = 1; v.eack = 1; v.eid = 2; v.wv = 3'b011; v.wa0 = 10; v.wp0 = 33;
    v.wa1 = 11; v.wp1 = 34; tbl.push_back(v);
    v = mk(3); v.req = 1; v.eack = 1; v.eid = 3; v.wv = 3'b001; v.wa0 = 10; v.wp0 = 35; tbl.push_back(v);
    v = mk(4); v.req = 1; tbl.push_back(v);
    v = mk(4); v.req = 1; v.fr = 1; tbl.push_back(v);
    v = mk(3); v.req = 1; v.eack = 1; v.eid = 0; tbl.push_back(v);
    // Test 6: recover to id 2 with free/req/write in the same cycle
    v = mk(4); v.rec = 1; v.rid = 2; v.fr = 1; v.req = 1; v.wv = 3'b001; v.wa0 = 12; v.wp0 = 36;
    v.r1a = 10; v.e1p = 35; v.e1r = 0; v.r2a = 11; v.e2p = 34; v.e2r = 0; tbl.push_back(v);
    v = mk(1); v.r1a = 10; v.e1p = 33; v.e1r = 0; v.r2a = 11; v.e2p = 11; v.toa = 12; v.etp = 12;
    v.req = 1; v.eack = 1; v.eid = 3; tbl.push_back(v);
    v = mk(2); v.fr = 1; v.wv = 3'b001; v.wa0 = 10; v.wp0 = 37; v.cv = 3'b001; v.cp0 = 33;
    v.r1a = 10; v.e1p = 33; v.e1r = 0; tbl.push_back(v);
    v = mk(1); v.rec = 1; v.rid = 3; v.fr = 1; v.r1a = 10; v.e1p = 37; v.e1r = 0; tbl.push_back(v);
    v = mk(0); v.r1a = 10; v.e1p = 33; v.req = 1; v.eack = 1; v.eid = 0; tbl.push_back(v);
    v = mk(1); tbl.push_back(v);

    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clock);
      apply(tbl[k]);
      if (tbl[k].rst) reset_n = 1'b0;
      #1;
      chk($sformatf("row%0d rs1_ptag", k), rs1_ptag[5:0], tbl[k].e1p);
      chk($sformatf("row%0d rs1_ready", k), rs1_ready[0], tbl[k].e1r);
      chk($sformatf("row%0d rs2_ptag", k), rs2_ptag[5:0], tbl[k].e2p);
      chk($sformatf("row%0d rs2_ready", k), rs2_ready[0], tbl[k].e2r);
      chk($sformatf("row%0d told_ptag", k), told_ptag[5:0], tbl[k].etp);
      chk($sformatf("row%0d told_ready", k), told_ready[0], tbl[k].etr);
      chk($sformatf("row%0d ckpt_ack", k), ckpt_ack, tbl[k].eack);
      if (tbl[k].eack) chk($sformatf("row%0d ckpt_id", k), ckpt_id, tbl[k].eid);
      chk($sformatf("row%0d ckpt_count", k), ckpt_count, tbl[k].ecnt);
      chk($sformatf("row%0d ckpt_full", k), ckpt_full, tbl[k].ecnt == 3'd4);
      if (tbl[k].rst) begin
        #1 reset_n = 1'b1;
      end
    end

    // Checkpoint covering slots 0..1 only, with a same-cycle CDB on the checkpointed tag
    @(negedge clock);
    idle_inputs();
    wr_valid = 3'b111;
    wr_arch  = {5'd22, 5'd21, 5'd20};
    wr_ptag  = {6'd46, 6'd45, 6'd44};
    cdb_valid = 3'b010; cdb_ptag = {6'd0, 6'd45, 6'd0};
    ckpt_req = 1'b1; ckpt_slot = 2'd1;
    #1;
    chk("part ckpt_ack", ckpt_ack, 1'b1);
    chk("part ckpt_id", ckpt_id, 2'd1);
    @(negedge clock);
    idle_inputs();
    rs1_arch = {5'd0, 5'd20, 5'd0}; rs2_arch = {5'd21, 5'd0, 5'd0}; told_arch = {5'd0, 5'd22, 5'd0};
    #1;
    chk("live r21 ptag", rs2_ptag[17:12], 6'd45);
    chk("live r21 ready", rs2_ready[2], 1'b1);
    chk("live r22 ptag", told_ptag[11:6], 6'd46);
    chk("live r22 ready", told_ready[1], 1'b0);
    chk("part count", ckpt_count, 3'd2);
    recover_en = 1'b1; recover_id = 2'd1;
    @(negedge clock);
    recover_en = 1'b0;
    #1;
    chk("rest r20 ptag", rs1_ptag[11:6], 6'd44);
    chk("rest r20 ready", rs1_ready[1], 1'b0);
    chk("rest r21 ptag", rs2_ptag[17:12], 6'd45);
    chk("rest r21 ready", rs2_ready[2], 1'b1);
    chk("rest r22 ptag", told_ptag[11:6], 6'd22);
    chk("rest r22 ready", told_ready[1], 1'b1);
    chk("rest count", ckpt_count, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
